// File: rtl/counter_event_mon.sv
// counter_event_mon: watches an 8-bit counter stream for overflow,
// underflow and compare-match events and queues one record per event
// cycle in a 4-deep FIFO. Records that arrive while the FIFO is full
// are dropped and flagged on the sticky evt_drop output.
//
// Optional build macro CNT_EVT_TIMESTAMP_EN adds a 16-bit free-running
// cycle counter that is captured into each record and presented on evt_ts.
module counter_event_mon (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cnt_in,
  input  logic       cnt_up,
  input  logic       cnt_load,
  input  logic       cmp_en,
  input  logic [7:0] cmp_val,
  input  logic       drop_clr,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] evt_flags,
  output logic [7:0] evt_value,
  output logic [2:0] evt_level,
  output logic       evt_drop
`ifdef CNT_EVT_TIMESTAMP_EN
  ,
  output logic [15:0] evt_ts
`endif
);

  logic [7:0] prev_cnt;
  logic       prev_ok;

  logic       ovf;
  logic       unf;
  logic       cmp;
  logic [2:0] flags;
  logic       push;
  logic       pop;
  logic       full;
  logic       wr_en;
  logic       drop;

  logic [2:0] mem_flags [4];
  logic [7:0] mem_value [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;

`ifdef CNT_EVT_TIMESTAMP_EN
  logic [15:0] ts_cnt;
  logic [15:0] mem_ts [4];
`endif

  // Event detection on the current sample against the previous one.
  // A parallel load is never a wrap; a held value matches only once.
  always_comb begin
    ovf   = prev_ok & ~cnt_load & cnt_up & (prev_cnt == 8'hFF) & (cnt_in == 8'h00);
    unf   = prev_ok & ~cnt_load & ~cnt_up & (prev_cnt == 8'h00) & (cnt_in == 8'hFF);
    cmp   = cmp_en & (cnt_in == cmp_val) & (~prev_ok | (prev_cnt != cmp_val));
    flags = {cmp, unf, ovf};
    push  = |flags;
  end

  // FIFO handshake: a pop frees the head slot in the same cycle, so a
  // push into a full FIFO with a simultaneous pop is accepted.
  always_comb begin
    full  = (count == 3'd4);
    pop   = evt_valid & evt_ready;
    wr_en = push & (~full | pop);
    drop  = push & full & ~pop;
  end

  // Previous-sample register used for wrap and hold detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_cnt <= 8'h00;
      prev_ok  <= 1'b0;
    end else begin
      prev_cnt <= cnt_in;
      prev_ok  <= 1'b1;
    end
  end

  // FIFO storage and pointers; occupancy tracked explicitly 0..4.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        mem_flags[i] <= 3'b000;
        mem_value[i] <= 8'h00;
      end
    end else begin
      if (wr_en) begin
        mem_flags[wr_ptr] <= flags;
        mem_value[wr_ptr] <= cnt_in;
        wr_ptr            <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag; a drop in the same cycle as drop_clr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_drop <= 1'b0;
    end else if (drop) begin
      evt_drop <= 1'b1;
    end else if (drop_clr) begin
      evt_drop <= 1'b0;
    end
  end

`ifdef CNT_EVT_TIMESTAMP_EN
  // Free-running cycle counter and per-record timestamp capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt <= 16'h0000;
      for (int i = 0; i < 4; i++) begin
        mem_ts[i] <= 16'h0000;
      end
    end else begin
      ts_cnt <= ts_cnt + 16'd1;
      if (wr_en) begin
        mem_ts[wr_ptr] <= ts_cnt;
      end
    end
  end

  assign evt_ts = evt_valid ? mem_ts[rd_ptr] : 16'h0000;
`endif

  // Head record outputs are zero whenever the FIFO is empty.
  always_comb begin
    evt_level = count;
    evt_valid = (count != 3'd0);
    evt_flags = evt_valid ? mem_flags[rd_ptr] : 3'b000;
    evt_value = evt_valid ? mem_value[rd_ptr] : 8'h00;
  end

endmodule

// File: tb/tb_counter_event_mon.sv
// Self-checking bench for counter_event_mon: directed scenarios followed
// by randomized traffic, all checked every cycle against a queue-based
// model of the event rules.
module tb_counter_event_mon;

  logic       clk;
  logic       rst;
  logic [7:0] cnt_in;
  logic       cnt_up;
  logic       cnt_load;
  logic       cmp_en;
  logic [7:0] cmp_val;
  logic       drop_clr;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_flags;
  logic [7:0] evt_value;
  logic [2:0] evt_level;
  logic       evt_drop;

  int n_cmp;
  int n_err;

  // model state
  logic [10:0] mq[$];
  logic [7:0]  m_prev;
  logic        m_prev_ok;
  logic        m_drop;

  logic        dir;

  counter_event_mon dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .cnt_up    (cnt_up),
    .cnt_load  (cnt_load),
    .cmp_en    (cmp_en),
    .cmp_val   (cmp_val),
    .drop_clr  (drop_clr),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_flags (evt_flags),
    .evt_value (evt_value),
    .evt_level (evt_level),
    .evt_drop  (evt_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one edge from the current inputs.
  task automatic model_edge();
    logic       ovf;
    logic       unf;
    logic       cmp;
    logic [2:0] f;
    logic       popped;
    logic       was_full;
    logic       lost;
    if (rst) begin
      mq.delete();
      m_prev    = 8'h00;
      m_prev_ok = 1'b0;
      m_drop    = 1'b0;
      return;
    end
    ovf = m_prev_ok && !cnt_load && cnt_up && m_prev == 8'hFF && cnt_in == 8'h00;
    unf = m_prev_ok && !cnt_load && !cnt_up && m_prev == 8'h00 && cnt_in == 8'hFF;
    cmp = cmp_en && cnt_in == cmp_val && (!m_prev_ok || m_prev != cmp_val);
    f = {cmp, unf, ovf};
    was_full = (mq.size() == 4);
    popped = (mq.size() != 0) && evt_ready;
    lost = 1'b0;
    if (popped) void'(mq.pop_front());
    if (f != 3'b000) begin
      if (was_full && !popped) lost = 1'b1;
      else mq.push_back({f, cnt_in});
    end
    if (lost) m_drop = 1'b1;
    else if (drop_clr) m_drop = 1'b0;
    m_prev    = cnt_in;
    m_prev_ok = 1'b1;
  endtask

  task automatic tick();
    logic [10:0] head;
    model_edge();
    @(posedge clk);
    #1;
    head = (mq.size() != 0) ? mq[0] : 11'h000;
    chk("level", 32'(evt_level), 32'(mq.size()));
    chk("valid", 32'(evt_valid), 32'(mq.size() != 0));
    chk("flags", 32'(evt_flags), 32'(head[10:8]));
    chk("value", 32'(evt_value), 32'(head[7:0]));
    chk("drop",  32'(evt_drop),  32'(m_drop));
  endtask

  task automatic drive(input logic [7:0] v, input logic up, input logic ld);
    cnt_in   = v;
    cnt_up   = up;
    cnt_load = ld;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_prev = 8'h00;
    m_prev_ok = 1'b0;
    m_drop = 1'b0;
    rst = 1'b1;
    cnt_in = 8'h00;
    cnt_up = 1'b1;
    cnt_load = 1'b0;
    cmp_en = 1'b0;
    cmp_val = 8'h00;
    drop_clr = 1'b0;
    evt_ready = 1'b1;
    dir = 1'b1;

    tick();
    tick();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_level", 32'(evt_level), 32'd0);
    chk("rst_flags", 32'(evt_flags), 32'd0);
    chk("rst_value", 32'(evt_value), 32'd0);
    chk("rst_drop",  32'(evt_drop),  32'd0);
    rst = 1'b0;

    // up-count through the wrap
    drive(8'hFD, 1'b1, 1'b0);
    drive(8'hFE, 1'b1, 1'b0);
    drive(8'hFF, 1'b1, 1'b0);
    chk("ovf_before", 32'(evt_valid), 32'd0);
    drive(8'h00, 1'b1, 1'b0);
    chk("ovf_valid", 32'(evt_valid), 32'd1);
    chk("ovf_flags", 32'(evt_flags), 32'b001);
    chk("ovf_value", 32'(evt_value), 32'h00);
    drive(8'h01, 1'b1, 1'b0);
    chk("ovf_once", 32'(evt_level), 32'd0);
    drive(8'h02, 1'b1, 1'b0);

    // down-count through the wrap with compare on FF
    cmp_en = 1'b1;
    cmp_val = 8'hFF;
    drive(8'h01, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    drive(8'hFF, 1'b0, 1'b0);
    chk("unf_flags", 32'(evt_flags), 32'b110);
    chk("unf_value", 32'(evt_value), 32'hFF);
    chk("unf_level", 32'(evt_level), 32'd1);
    drive(8'hFF, 1'b0, 1'b0);

    // held value matches once; load onto 00 after FF is no overflow
    cmp_val = 8'h10;
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive(8'h10, 1'b1, 1'b0);
    chk("hold_once", 32'(evt_level), 32'd1);
    chk("hold_flags", 32'(evt_flags), 32'b100);
    evt_ready = 1'b1;
    drive(8'h10, 1'b1, 1'b0);
    cmp_en = 1'b0;
    drive(8'hFF, 1'b1, 1'b0);
    drive(8'h00, 1'b1, 1'b1);
    chk("load_no_ovf", 32'(evt_level), 32'd0);

    // overflow the FIFO with six distinct compare records
    evt_ready = 1'b0;
    cmp_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmp_val = 8'h20 + 8'(i);
      drive(8'h20 + 8'(i), 1'b1, 1'b1);
    end
    chk("full_level", 32'(evt_level), 32'd4);
    chk("full_drop", 32'(evt_drop), 32'd1);
    chk("full_head", 32'(evt_value), 32'h20);
    cmp_en = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 32'(evt_value), 32'h20 + 32'(i));
      tick();
    end
    chk("drain_empty", 32'(evt_level), 32'd0);
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    chk("drop_clr", 32'(evt_drop), 32'd0);

    // push and pop together while full
    evt_ready = 1'b0;
    cmp_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmp_val = 8'h30 + 8'(i);
      drive(8'h30 + 8'(i), 1'b1, 1'b1);
    end
    chk("fill4", 32'(evt_level), 32'd4);
    evt_ready = 1'b1;
    cmp_val = 8'h34;
    drive(8'h34, 1'b1, 1'b1);
    chk("pp_level", 32'(evt_level), 32'd4);
    chk("pp_drop", 32'(evt_drop), 32'd0);
    chk("pp_head", 32'(evt_value), 32'h31);
    cmp_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pp_empty", 32'(evt_level), 32'd0);

    // reset mid-stream
    evt_ready = 1'b0;
    cmp_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmp_val = 8'h40 + 8'(i);
      drive(8'h40 + 8'(i), 1'b1, 1'b1);
    end
    chk("pre_rst_level", 32'(evt_level), 32'd3);
    cmp_en = 1'b0;
    drive(8'hFF, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_valid", 32'(evt_valid), 32'd0);
    chk("post_rst_level", 32'(evt_level), 32'd0);
    drive(8'h00, 1'b1, 1'b0);
    chk("post_rst_no_ovf", 32'(evt_level), 32'd0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      drop_clr = ($urandom_range(0, 15) == 0);
      if ((c % 64) < 24) evt_ready = ($urandom_range(0, 3) == 0);
      else evt_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) cmp_en = ~cmp_en;
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0: cnt_in = 8'hFE;
          1: cnt_in = 8'h01;
          default: cnt_in = 8'($urandom);
        endcase
        cnt_load = 1'b1;
        cnt_up = 1'($urandom);
      end else begin
        if ($urandom_range(0, 7) == 0) dir = ~dir;
        cnt_in = dir ? cnt_in + 8'd1 : cnt_in - 8'd1;
        cnt_up = dir;
        cnt_load = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) cmp_val = cnt_in;
      else if ($urandom_range(0, 7) == 0) cmp_val = 8'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counter_event_mon.md
COUNTER_EVENT_MON -- requirements
Module: counter_event_mon

Interface
REQ-001 The block SHALL have these ports, in this order:
  clk  in  1  clock; all logic on rising edge
  rst  in  1  synchronous, active-high reset
  cnt_in  in  8  counter value, sampled every clk
  cnt_up  in  1  direction that produced cnt_in (1=up, 0=down)
  cnt_load  in  1  cnt_in came from a parallel load this cycle
  cmp_en  in  1  enable compare-match detection
  cmp_val  in  8  compare value
  drop_clr  in  1  clears evt_drop
  evt_valid  out  1  event record available at FIFO head
  evt_ready  in  1  consumer accepts head record
  evt_flags  out  3  head record flags {cmp, unf, ovf}
  evt_value  out  8  head record counter value
  evt_level  out  3  FIFO occupancy, 0..4
  evt_drop  out  1  sticky: a record was lost

Function
REQ-002 The block SHALL register the previous sample in prev_cnt and set prev_ok after the first post-reset sample.
REQ-003 ovf SHALL be 1 when prev_ok & !cnt_load & cnt_up & prev_cnt==8'hFF & cnt_in==8'h00.
REQ-004 unf SHALL be 1 when prev_ok & !cnt_load & !cnt_up & prev_cnt==8'h00 & cnt_in==8'hFF.
REQ-005 cmp SHALL be 1 when cmp_en & cnt_in==cmp_val & (!prev_ok | prev_cnt!=cmp_val); a value held constant SHALL match only once.
REQ-006 A cnt_load that lands on cmp_val SHALL raise cmp; a load SHALL never raise ovf or unf.
REQ-007 Any nonzero flag set SHALL push exactly one record {flags, cnt_in}; multiple flags in one cycle SHALL share one record.
REQ-008 The FIFO SHALL be 4 deep and first-in first-out; pop SHALL occur when evt_valid & evt_ready.
REQ-009 A record pushed at edge N into an empty FIFO SHALL be visible on evt_valid/evt_flags/evt_value after edge N (1-cycle latency).
REQ-010 evt_flags/evt_value SHALL hold steady while evt_valid & !evt_ready.
REQ-011 Push and pop in the same cycle SHALL both take effect, including when full (level stays 4, no drop).
REQ-012 A push while full without pop SHALL discard the new record and set evt_drop.
REQ-013 evt_drop SHALL clear on drop_clr unless a drop occurs that same cycle (set wins).
REQ-014 evt_level SHALL equal the registered occupancy; evt_valid SHALL equal (evt_level!=0).

Reset
REQ-015 On rst: FIFO empty, evt_valid=0, evt_level=0, evt_flags=0, evt_value=0, evt_drop=0, prev_cnt=0, prev_ok=0.
REQ-016 rst asserted mid-stream SHALL discard all queued records; the first sample after reset SHALL not raise ovf/unf.

Configuration
REQ-017 With CNT_EVT_TIMESTAMP_EN defined: a 16-bit free-running cycle counter (reset 0, wraps 16'hFFFF->0) SHALL be stored per record and presented on extra output evt_ts[15:0] (reset value 0).
REQ-018 Without CNT_EVT_TIMESTAMP_EN: no timestamp counter, no evt_ts port; all other behaviour unchanged.

Verification
REQ-019 Up-count 8'hFD..8'h02, cmp_en=0, evt_ready=1 -> one record flags=3'b001 value=8'h00, one cycle after the wrap sample.
REQ-020 Down-count 8'h01,8'h00,8'hFF, cmp_en=1, cmp_val=8'hFF -> one record flags=3'b110 value=8'hFF.
REQ-021 Hold cnt_in=8'h10 five cycles, cmp_val=8'h10 -> exactly one cmp record; prev 8'hFF then load 8'h00 -> no ovf.
REQ-022 evt_ready=0, six events -> evt_level=4, evt_drop=1, head holds first record; drain -> records 1-4 in order.
REQ-023 Full FIFO, event with evt_ready=1 same cycle -> level stays 4, evt_drop stays 0.
REQ-024 rst pulse with level=3 -> next cycle evt_valid=0, evt_level=0; next FF->00 sample raises no ovf.
